control_sequencer: RTL and testbench

Hardwired control unit that drives every control input of the ALU-system datapath (register file, address register file, ALU, IR, DR, memory, muxes A–D). It fetches a 16-bit instruction as two byte reads at PC, decodes `IROut` and sequences execute cycles. It reads `ALU_FlagsOut` to resolve conditional branches. It is the stage directly upstream of the datapath, with outputs wired 1:1 to its like-named inputs.

---
 rtl/control_sequencer_if.sv | 49 ++++
 rtl/control_sequencer.sv | 188 ++++++++++++++++++
 tb/tb_control_sequencer.sv | 251 +++++++++++++++++++++++++
 3 files changed

// File: rtl/control_sequencer_if.sv
// Bus between the control sequencer and the ALU-system datapath.
// The sequencer reads the instruction register and flags and drives
// every datapath control input; State/Halted are debug observables.
interface control_sequencer_if;
    logic [15:0] IROut;
    logic [3:0]  ALU_FlagsOut;

    logic [2:0]  RF_OutASel;
    logic [2:0]  RF_OutBSel;
    logic [2:0]  RF_FunSel;
    logic [3:0]  RF_RegSel;
    logic [3:0]  RF_ScrSel;
    logic [4:0]  ALU_FunSel;
    logic        ALU_WF;
    logic [2:0]  ARF_RegSel;
    logic [1:0]  ARF_FunSel;
    logic [1:0]  ARF_OutCSel;
    logic [1:0]  ARF_OutDSel;
    logic        IR_Write;
    logic        IR_LH;
    logic        Mem_WR;
    logic        Mem_CS;
    logic [1:0]  MuxASel;
    logic [1:0]  MuxBSel;
    logic [1:0]  MuxCSel;
    logic        MuxDSel;
    logic        DR_E;
    logic [1:0]  DR_FunSel;
    logic [2:0]  State;
    logic        Halted;

    // Sequencer side.
    modport master (
        input  IROut, ALU_FlagsOut,
        output RF_OutASel, RF_OutBSel, RF_FunSel, RF_RegSel, RF_ScrSel,
               ALU_FunSel, ALU_WF, ARF_RegSel, ARF_FunSel, ARF_OutCSel,
               ARF_OutDSel, IR_Write, IR_LH, Mem_WR, Mem_CS, MuxASel,
               MuxBSel, MuxCSel, MuxDSel, DR_E, DR_FunSel, State, Halted
    );

    // Datapath side.
    modport slave (
        output IROut, ALU_FlagsOut,
        input  RF_OutASel, RF_OutBSel, RF_FunSel, RF_RegSel, RF_ScrSel,
               ALU_FunSel, ALU_WF, ARF_RegSel, ARF_FunSel, ARF_OutCSel,
               ARF_OutDSel, IR_Write, IR_LH, Mem_WR, Mem_CS, MuxASel,
               MuxBSel, MuxCSel, MuxDSel, DR_E, DR_FunSel, State, Halted
    );
endinterface

// File: rtl/control_sequencer.sv
// Hardwired control unit for the ALU-system datapath.
// Fetches a 16-bit instruction as two byte reads at PC, then decodes IROut
// in EXEC (and EXEC2 for LDR). Outputs are combinational from the state and
// IROut and are forced to idle values while Reset is low.
// State encoding seen on State: PCCLR=0, FETCH_L=1, FETCH_H=2, EXEC=3,
// EXEC2=4, HALT=5.
module control_sequencer (
    input  logic                Clock,
    input  logic                Reset,
    control_sequencer_if.master bus
);

    typedef enum logic [2:0] {
        PCCLR   = 3'd0,
        FETCH_L = 3'd1,
        FETCH_H = 3'd2,
        EXEC    = 3'd3,
        EXEC2   = 3'd4,
        HALT    = 3'd5
    } state_t;

    localparam logic [5:0] OP_BRA = 6'h00;
    localparam logic [5:0] OP_BNE = 6'h01;
    localparam logic [5:0] OP_BEQ = 6'h02;
    localparam logic [5:0] OP_LDI = 6'h03;
    localparam logic [5:0] OP_ADD = 6'h04;
    localparam logic [5:0] OP_SUB = 6'h05;
    localparam logic [5:0] OP_AND = 6'h06;
    localparam logic [5:0] OP_ORR = 6'h07;
    localparam logic [5:0] OP_STR = 6'h08;
    localparam logic [5:0] OP_LDR = 6'h09;
    localparam logic [5:0] OP_HLT = 6'h3F;

    localparam logic [2:0] ARF_PC = 3'b100;
    localparam logic [2:0] ARF_AR = 3'b010;

    state_t      state;
    state_t      state_next;

    logic [5:0]  op;
    logic [1:0]  rd;
    logic [1:0]  rs1;
    logic [1:0]  rs2;
    logic        flag_z;
    logic [3:0]  rd_onehot;
    logic        unused_bits;

    assign op        = bus.IROut[15:10];
    assign rd        = bus.IROut[9:8];
    assign rs1       = bus.IROut[7:6];
    assign rs2       = bus.IROut[5:4];
    assign flag_z    = bus.ALU_FlagsOut[3];
    // R1 sits in bit 3, so Rd=0 maps to 4'b1000.
    assign rd_onehot = 4'b1000 >> rd;
    // Immediate bits feed the datapath directly; C/N/O are never branched on.
    assign unused_bits = ^{bus.IROut[3:0], bus.ALU_FlagsOut[2:0]};

    assign bus.State = state;

    // State register: asynchronous return to PCCLR while Reset is low.
    always_ff @(posedge Clock or negedge Reset) begin
        // NOTE: non-blocking so every flop samples pre-edge values.
        if (!Reset) state <= PCCLR;
        else        state <= state_next;
    end

    // Next-state logic: fetch/execute sequencing, HALT is absorbing.
    always_comb begin
        // NOTE: default first so no path leaves state_next unassigned (no latch).
        state_next = state;
        unique case (state)
            PCCLR:   state_next = FETCH_L;
            FETCH_L: state_next = FETCH_H;
            FETCH_H: state_next = EXEC;
            EXEC: begin
                if (op == OP_LDR)      state_next = EXEC2;
                else if (op == OP_HLT) state_next = HALT;
                else                   state_next = FETCH_L;
            end
            EXEC2:   state_next = FETCH_L;
            HALT:    state_next = HALT;
            default: state_next = PCCLR;
        endcase
    end

    // Output logic: idle word overridden per state; IROut is only decoded in EXEC/EXEC2.
    always_comb begin
        bus.RF_OutASel  = 3'b000;
        bus.RF_OutBSel  = 3'b000;
        bus.RF_FunSel   = 3'b000;
        bus.RF_RegSel   = 4'b0000;
        bus.RF_ScrSel   = 4'b0000;
        bus.ALU_FunSel  = 5'b00000;
        bus.ALU_WF      = 1'b0;
        bus.ARF_RegSel  = 3'b000;
        bus.ARF_FunSel  = 2'b00;
        bus.ARF_OutCSel = 2'b00;
        bus.ARF_OutDSel = 2'b00;
        bus.IR_Write    = 1'b0;
        bus.IR_LH       = 1'b0;
        bus.Mem_WR      = 1'b0;
        bus.Mem_CS      = 1'b1;
        bus.MuxASel     = 2'b00;
        bus.MuxBSel     = 2'b00;
        bus.MuxCSel     = 2'b00;
        bus.MuxDSel     = 1'b0;
        bus.DR_E        = 1'b0;
        bus.DR_FunSel   = 2'b00;
        bus.Halted      = 1'b0;

        // Gating on Reset makes a mid-write reset release memory immediately.
        if (Reset) begin
            unique case (state)
                PCCLR: begin
                    bus.ARF_RegSel = ARF_PC;
                    bus.ARF_FunSel = 2'b11;
                end
                FETCH_L, FETCH_H: begin
                    bus.ARF_OutDSel = 2'b00;
                    bus.Mem_CS      = 1'b0;
                    bus.IR_Write    = 1'b1;
                    bus.IR_LH       = (state == FETCH_H);
                    bus.ARF_RegSel  = ARF_PC;
                    bus.ARF_FunSel  = 2'b01;
                end
                EXEC: begin
                    case (op)
                        OP_BRA, OP_BNE, OP_BEQ: begin
                            if ((op == OP_BRA) ||
                                (op == OP_BNE && !flag_z) ||
                                (op == OP_BEQ &&  flag_z)) begin
                                bus.MuxBSel    = 2'b11;
                                bus.ARF_RegSel = ARF_PC;
                                bus.ARF_FunSel = 2'b10;
                            end
                        end
                        OP_LDI: begin
                            bus.MuxASel   = 2'b11;
                            bus.RF_RegSel = rd_onehot;
                            bus.RF_FunSel = 3'b010;
                        end
                        OP_ADD, OP_SUB, OP_AND, OP_ORR: begin
                            bus.RF_OutASel = {1'b0, rs1};
                            bus.RF_OutBSel = {1'b0, rs2};
                            bus.MuxDSel    = 1'b0;
                            bus.ALU_WF     = 1'b1;
                            bus.MuxASel    = 2'b00;
                            bus.RF_RegSel  = rd_onehot;
                            bus.RF_FunSel  = 3'b010;
                            case (op)
                                OP_ADD:  bus.ALU_FunSel = 5'b10100;
                                OP_SUB:  bus.ALU_FunSel = 5'b10110;
                                OP_AND:  bus.ALU_FunSel = 5'b10111;
                                default: bus.ALU_FunSel = 5'b11000;
                            endcase
                        end
                        OP_STR: begin
                            // Write M[AR] <= Rs1 through the ALU pass-A path; AR++ commits at the edge.
                            bus.RF_OutASel  = {1'b0, rs1};
                            bus.ALU_FunSel  = 5'b10000;
                            bus.MuxCSel     = 2'b00;
                            bus.ARF_OutDSel = 2'b01;
                            bus.Mem_CS      = 1'b0;
                            bus.Mem_WR      = 1'b1;
                            bus.ARF_RegSel  = ARF_AR;
                            bus.ARF_FunSel  = 2'b01;
                        end
                        OP_LDR: begin
                            bus.ARF_OutDSel = 2'b01;
                            bus.Mem_CS      = 1'b0;
                            bus.DR_E        = 1'b1;
                            bus.DR_FunSel   = 2'b10;
                        end
                        default: ;
                    endcase
                end
                EXEC2: begin
                    bus.MuxASel   = 2'b10;
                    bus.RF_RegSel = rd_onehot;
                    bus.RF_FunSel = 3'b010;
                end
                HALT:    bus.Halted = 1'b1;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_control_sequencer.sv
// Scoreboard bench for control_sequencer. A driver issues whole instructions
// (fetch bytes + execute) and queues the control word each cycle must show;
// a monitor on the falling edge pops and compares.
module tb_control_sequencer;

    localparam logic [2:0] S_PCCLR = 3'd0;
    localparam logic [2:0] S_FL    = 3'd1;
    localparam logic [2:0] S_FH    = 3'd2;
    localparam logic [2:0] S_EXEC  = 3'd3;
    localparam logic [2:0] S_EXEC2 = 3'd4;
    localparam logic [2:0] S_HALT  = 3'd5;

    typedef struct packed {
        logic [2:0] outa;
        logic [2:0] outb;
        logic [2:0] rf_fun;
        logic [3:0] rf_reg;
        logic [3:0] rf_scr;
        logic [4:0] alu_fun;
        logic       alu_wf;
        logic [2:0] arf_reg;
        logic [1:0] arf_fun;
        logic [1:0] outc;
        logic [1:0] outd;
        logic       ir_write;
        logic       ir_lh;
        logic       mem_wr;
        logic       mem_cs;
        logic [1:0] muxa;
        logic [1:0] muxb;
        logic [1:0] muxc;
        logic       muxd;
        logic       dr_e;
        logic [1:0] dr_fun;
        logic [2:0] state;
        logic       halted;
    } ctrl_t;

    logic Clock;
    logic Reset;
    control_sequencer_if bus();

    control_sequencer dut (
        .Clock (Clock),
        .Reset (Reset),
        .bus   (bus.master)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    int    n_tests = 0;
    int    n_fail  = 0;
    ctrl_t exp_q[$];
    ctrl_t mon_exp;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @%0t: got %h, want %h", name, $time, act, exp);
        end
    endtask

    function automatic ctrl_t sample();
        ctrl_t c;
        c.outa     = bus.RF_OutASel;
        c.outb     = bus.RF_OutBSel;
        c.rf_fun   = bus.RF_FunSel;
        c.rf_reg   = bus.RF_RegSel;
        c.rf_scr   = bus.RF_ScrSel;
        c.alu_fun  = bus.ALU_FunSel;
        c.alu_wf   = bus.ALU_WF;
        c.arf_reg  = bus.ARF_RegSel;
        c.arf_fun  = bus.ARF_FunSel;
        c.outc     = bus.ARF_OutCSel;
        c.outd     = bus.ARF_OutDSel;
        c.ir_write = bus.IR_Write;
        c.ir_lh    = bus.IR_LH;
        c.mem_wr   = bus.Mem_WR;
        c.mem_cs   = bus.Mem_CS;
        c.muxa     = bus.MuxASel;
        c.muxb     = bus.MuxBSel;
        c.muxc     = bus.MuxCSel;
        c.muxd     = bus.MuxDSel;
        c.dr_e     = bus.DR_E;
        c.dr_fun   = bus.DR_FunSel;
        c.state    = bus.State;
        c.halted   = bus.Halted;
        return c;
    endfunction

    // ---------------- reference model: control word per cycle kind ----------------
    function automatic ctrl_t w_idle(input logic [2:0] st);
        ctrl_t c = '0;
        c.mem_cs = 1'b1;
        c.state  = st;
        return c;
    endfunction

    function automatic ctrl_t w_pcclr();
        ctrl_t c = w_idle(S_PCCLR);
        c.arf_reg = 3'b100;
        c.arf_fun = 2'b11;
        return c;
    endfunction

    function automatic ctrl_t w_fetch(input bit hi);
        ctrl_t c = w_idle(hi ? S_FH : S_FL);
        c.arf_reg  = 3'b100;
        c.arf_fun  = 2'b01;
        c.outd     = 2'b00;
        c.mem_cs   = 1'b0;
        c.ir_write = 1'b1;
        c.ir_lh    = hi;
        return c;
    endfunction

    function automatic ctrl_t w_halt();
        ctrl_t c = w_idle(S_HALT);
        c.halted = 1'b1;
        return c;
    endfunction

    function automatic logic [3:0] reg_bit(input logic [1:0] r);
        return 4'(1 << (3 - int'(r)));
    endfunction

    function automatic ctrl_t w_exec(input logic [15:0] ir, input logic [3:0] fl);
        ctrl_t c = w_idle(S_EXEC);
        int op = int'(ir[15:10]);
        bit z  = fl[3];
        bit take = (op == 0) || (op == 1 && !z) || (op == 2 && z);
        if (op <= 2 && take) begin
            c.muxb = 2'b11; c.arf_reg = 3'b100; c.arf_fun = 2'b10;
        end else if (op == 3) begin
            c.muxa = 2'b11; c.rf_reg = reg_bit(ir[9:8]); c.rf_fun = 3'b010;
        end else if (op >= 4 && op <= 7) begin
            c.outa = {1'b0, ir[7:6]}; c.outb = {1'b0, ir[5:4]};
            c.alu_wf = 1'b1; c.rf_reg = reg_bit(ir[9:8]); c.rf_fun = 3'b010;
            c.alu_fun = (op == 4) ? 5'b10100 : (op == 5) ? 5'b10110 :
                        (op == 6) ? 5'b10111 : 5'b11000;
        end else if (op == 8) begin
            c.outa = {1'b0, ir[7:6]}; c.alu_fun = 5'b10000;
            c.outd = 2'b01; c.mem_cs = 1'b0; c.mem_wr = 1'b1;
            c.arf_reg = 3'b010; c.arf_fun = 2'b01;
        end else if (op == 9) begin
            c.outd = 2'b01; c.mem_cs = 1'b0; c.dr_e = 1'b1; c.dr_fun = 2'b10;
        end
        return c;
    endfunction

    function automatic ctrl_t w_exec2(input logic [15:0] ir);
        ctrl_t c = w_idle(S_EXEC2);
        c.muxa   = 2'b10;
        c.rf_reg = reg_bit(ir[9:8]);
        c.rf_fun = 3'b010;
        return c;
    endfunction

    // ---------------- driver ----------------
    task automatic step(input logic rst, input logic [15:0] ir, input logic [3:0] fl, input ctrl_t exp);
        @(posedge Clock);
        #1;
        Reset            = rst;
        bus.IROut        = ir;
        bus.ALU_FlagsOut = fl;
        exp_q.push_back(exp);
    endtask

    // One instruction: two fetch cycles with junk on IROut, then execute.
    task automatic run_instr(input logic [15:0] ir, input logic [3:0] fl);
        step(1'b1, 16'($urandom), 4'($urandom), w_fetch(1'b0));
        step(1'b1, 16'($urandom), 4'($urandom), w_fetch(1'b1));
        step(1'b1, ir, fl, w_exec(ir, fl));
        if (ir[15:10] == 6'h09)
            step(1'b1, ir, 4'($urandom), w_exec2(ir));
    endtask

    function automatic logic [15:0] rand_instr();
        int sel = int'($urandom_range(0, 10));
        logic [5:0] op = (sel == 10) ? 6'($urandom_range(10, 62)) : 6'(sel);
        return {op, 10'($urandom)};
    endfunction

    // ---------------- monitor ----------------
    initial begin
        forever begin
            @(negedge Clock);
            if (exp_q.size() != 0) begin
                mon_exp = exp_q.pop_front();
                check("ctrl_word", 64'(sample()), 64'(mon_exp));
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        Reset            = 1'b0;
        bus.IROut        = 16'h0;
        bus.ALU_FlagsOut = 4'h0;

        // Held in reset: idle outputs whatever IROut shows.
        repeat (3) step(1'b0, 16'($urandom), 4'($urandom), w_idle(S_PCCLR));
        step(1'b1, 16'($urandom), 4'($urandom), w_pcclr());

        // LDI R1,5; LDI R2,5; SUB R3,R1,R2; BEQ taken then not taken.
        run_instr({6'h03, 2'd0, 8'h05}, 4'h0);
        run_instr({6'h03, 2'd1, 8'h05}, 4'h0);
        run_instr({6'h05, 2'd2, 2'd0, 2'd1, 4'h0}, 4'h0);
        run_instr({6'h02, 2'd0, 8'h20}, 4'b1000);
        run_instr({6'h02, 2'd0, 8'h20}, 4'b0111);
        run_instr({6'h01, 2'd0, 8'h30}, 4'b1000);
        run_instr({6'h01, 2'd0, 8'h30}, 4'b0000);
        run_instr({6'h00, 2'd0, 8'h44}, 4'b1111);
        // STR R1 then LDR R4.
        run_instr({6'h08, 2'd0, 2'd0, 6'h00}, 4'h0);
        run_instr({6'h09, 2'd3, 8'h00}, 4'h0);

        repeat (200) run_instr(rand_instr(), 4'($urandom));

        // HLT: absorbing, ignores IROut and flags.
        run_instr({6'h3F, 10'($urandom)}, 4'($urandom));
        repeat (20) step(1'b1, 16'($urandom), 4'($urandom), w_halt());

        // Reset out of HALT, then reset in the middle of an STR execute.
        repeat (2) step(1'b0, 16'($urandom), 4'($urandom), w_idle(S_PCCLR));
        step(1'b1, 16'($urandom), 4'($urandom), w_pcclr());
        step(1'b1, 16'($urandom), 4'($urandom), w_fetch(1'b0));
        step(1'b1, 16'($urandom), 4'($urandom), w_fetch(1'b1));
        step(1'b1, {6'h08, 2'd1, 2'd2, 6'h00}, 4'h0, w_exec({6'h08, 2'd1, 2'd2, 6'h00}, 4'h0));
        @(negedge Clock);
        #2;
        Reset = 1'b0;
        #1;
        check("rst_mid_str_mem_wr", 64'(bus.Mem_WR), 64'd0);
        check("rst_mid_str_mem_cs", 64'(bus.Mem_CS), 64'd1);
        check("rst_mid_str_state",  64'(bus.State),  64'(S_PCCLR));
        step(1'b0, 16'($urandom), 4'($urandom), w_idle(S_PCCLR));
        step(1'b1, 16'($urandom), 4'($urandom), w_pcclr());
        run_instr({6'h03, 2'd2, 8'h7E}, 4'h0);

        repeat (2) @(negedge Clock);
        #1;
        check("queue_drained", 64'(exp_q.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
